// File: rtl/parity_gen_pkg.sv
// Shared types and sizes for the parity word generator.
// Optional build macro: PARITY_GEN_ERR_INJ_EN (adds err_inj input).
package parity_gen_pkg;

  localparam int DATA_W  = 4;
  localparam int COUNT_W = 5;
  localparam int GAP_W   = 4;
  localparam int WORDS   = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  function automatic logic is_last(
    input logic [DATA_W-1:0] data
  );
    return data == DATA_W'(WORDS - 1);
  endfunction

endpackage

// File: rtl/parity_gen_calc.sv
// Parity bit over a data word; ODD_PARITY selects
// whether data plus parity carries an odd count of ones.
module parity_calc
  import parity_gen_pkg::*;
#(
  parameter int ODD_PARITY = 0
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = (^data) ^ (ODD_PARITY != 0);

endmodule

// File: rtl/parity_gen.sv
// Sweeps 4-bit words 0..15 with parity to a valid/ready consumer.
// Build macro PARITY_GEN_ERR_INJ_EN adds the err_inj input.
module parity_gen
  import parity_gen_pkg::*;
#(
  parameter int ODD_PARITY = 0,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ready,
`ifdef PARITY_GEN_ERR_INJ_EN
  input  logic               err_inj,
`endif
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               e,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count
);

  localparam logic [GAP_W-1:0] GAP_LOAD =
    GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  state_t             state;
  state_t             state_n;
  logic [DATA_W-1:0]  data;
  logic [DATA_W-1:0]  data_n;
  logic [COUNT_W-1:0] count_n;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_n;
  logic               send;
  logic               par;
  logic               flip;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      data    <= '0;
      count   <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      data    <= data_n;
      count   <= count_n;
      gap_cnt <= gap_n;
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data;
    count_n = count;
    gap_n   = gap_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND;
          data_n  = '0;
          count_n = '0;
          gap_n   = '0;
        end
      end
      SEND: begin
        if (ready) begin
          count_n = count + 1'b1;
          if (is_last(data)) begin
            state_n = DONE;
          end else begin
            data_n = data + 1'b1;
            if (GAP_CYCLES != 0) begin
              state_n = GAP;
              gap_n   = GAP_LOAD;
            end
          end
        end
      end
      GAP: begin
        // gap_cnt was loaded with GAP_CYCLES-1 on entry
        if (gap_cnt == '0) state_n = SEND;
        else gap_n = gap_cnt - 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  parity_calc #(
    .ODD_PARITY(ODD_PARITY)
  ) u_calc (
    .data  (data),
    .parity(par)
  );

`ifdef PARITY_GEN_ERR_INJ_EN
  assign flip = err_inj;
`else
  assign flip = 1'b0;
`endif

  assign send         = state == SEND;
  assign {a, b, c, d} = send ? data : '0;
  assign e            = send & (par ^ flip);
  assign valid        = send;
  assign busy         = state != IDLE;
  assign done         = state == DONE;

endmodule

// File: tb/tb_parity_gen.sv
// Self-checking bench: u0 even/no gap, u1 odd/gap 2.
module tb_parity_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst = 2'b11;
  logic [1:0] start = 2'b00;
  logic [1:0] ready = 2'b00;
  logic [1:0] inj = 2'b00;
  logic [1:0] a, b, c, d, e;
  logic [1:0] valid, busy, done;
  logic [1:0][4:0] cnt;

  int checks = 0;
  int errors = 0;

  parity_gen #(.ODD_PARITY(0), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .ready(ready[0]),
`ifdef PARITY_GEN_ERR_INJ_EN
    .err_inj(inj[0]),
`endif
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .e(e[0]),
    .valid(valid[0]), .busy(busy[0]), .done(done[0]),
    .count(cnt[0])
  );

  parity_gen #(.ODD_PARITY(1), .GAP_CYCLES(2)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .ready(ready[1]),
`ifdef PARITY_GEN_ERR_INJ_EN
    .err_inj(inj[1]),
`endif
    .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]), .e(e[1]),
    .valid(valid[1]), .busy(busy[1]), .done(done[1]),
    .count(cnt[1])
  );

  function automatic int gapn(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  // parity chosen so the 5-bit word has ones-count parity == k
  function automatic logic exp_par(input int v, input int k);
    logic [3:0] w;
    w = v[3:0];
    return (($countones(w) + k) % 2) == 1;
  endfunction

  function automatic logic [3:0] dat(input int k);
    return {a[k], b[k], c[k], d[k]};
  endfunction

  function automatic logic [12:0] obs(input int k);
    return {valid[k], busy[k], done[k], cnt[k], dat(k), e[k]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    start[k] = 1'b0;
    ready[k] = 1'b0;
    inj[k] = 1'b0;
    tick();
    rst[k] = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 2'b11;
    start = 2'b11;
    ready = 2'b11;
    for (int n = 0; n < 2; n++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== 13'd0) begin
          errors++;
          $display("FAIL reset dut%0d got %h want 0", k, obs(k));
        end
      end
    end
    rst = 2'b00;
    start = 2'b00;
    ready = 2'b00;
  endtask

  task automatic test_sweep_gap0;
    logic [12:0] want;
    do_reset(0);
    ready[0] = 1'b1;
    pulse_start(0);
    for (int i = 0; i < 16; i++) begin
      want = {3'b110, 5'(i), 4'(i), exp_par(i, 0)};
      checks++;
      if (obs(0) !== want) begin
        errors++;
        $display("FAIL sweep0 word%0d got %h want %h", i, obs(0), want);
      end
      if (i == 7) begin
        checks++;
        if (e[0] !== 1'b1) begin
          errors++;
          $display("FAIL even_0111 got %b want 1", e[0]);
        end
      end
      tick();
    end
    want = {3'b011, 5'd16, 5'd0};
    checks++;
    if (obs(0) !== want) begin
      errors++;
      $display("FAIL sweep0 done got %h want %h", obs(0), want);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      want = {3'b000, 5'd16, 5'd0};
      checks++;
      if (obs(0) !== want) begin
        errors++;
        $display("FAIL sweep0 idle%0d got %h want %h", n, obs(0), want);
      end
    end
    ready[0] = 1'b0;
  endtask

  task automatic test_gap2;
    logic [12:0] want;
    logic        v;
    do_reset(1);
    ready[1] = 1'b1;
    pulse_start(1);
    for (int t = 0; t < 46; t++) begin
      v = (t % 3) == 0;
      want = {v, 2'b10, 5'((t + 2) / 3),
              v ? 4'(t / 3) : 4'd0,
              v ? exp_par(t / 3, 1) : 1'b0};
      checks++;
      if (obs(1) !== want) begin
        errors++;
        $display("FAIL gap2 t%0d got %h want %h", t, obs(1), want);
      end
      if (t == 21) begin
        checks++;
        if (e[1] !== 1'b0) begin
          errors++;
          $display("FAIL odd_0111 got %b want 0", e[1]);
        end
      end
      tick();
    end
    want = {3'b011, 5'd16, 5'd0};
    checks++;
    if (obs(1) !== want) begin
      errors++;
      $display("FAIL gap2 done got %h want %h", obs(1), want);
    end
    tick();
    ready[1] = 1'b0;
  endtask

  task automatic test_stall;
    logic [12:0] want;
    int          n;
    do_reset(0);
    ready[0] = 1'b1;
    pulse_start(0);
    n = 0;
    while (!(valid[0] === 1'b1 && dat(0) === 4'd3) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL stall_wait got timeout want word3");
    end
    ready[0] = 1'b0;
    want = {3'b110, 5'd3, 4'd3, exp_par(3, 0)};
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (obs(0) !== want) begin
        errors++;
        $display("FAIL stall%0d got %h want %h", j, obs(0), want);
      end
      tick();
    end
    ready[0] = 1'b1;
    tick();
    want = {3'b110, 5'd4, 4'd4, exp_par(4, 0)};
    checks++;
    if (obs(0) !== want) begin
      errors++;
      $display("FAIL stall_resume got %h want %h", obs(0), want);
    end
    ready[0] = 1'b0;
  endtask

  task automatic test_abort;
    int n;
    do_reset(1);
    ready[1] = 1'b1;
    pulse_start(1);
    n = 0;
    while (cnt[1] !== 5'd8 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL abort_wait got timeout want count8");
    end
    rst[1] = 1'b1;
    start[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    start[1] = 1'b0;
    checks++;
    if (obs(1) !== 13'd0) begin
      errors++;
      $display("FAIL abort got %h want 0", obs(1));
    end
    for (int j = 0; j < 30; j++) begin
      tick();
      checks++;
      if ({done[1], busy[1], valid[1]} !== 3'b000) begin
        errors++;
        $display("FAIL abort_idle%0d got %b want 000", j,
                 {done[1], busy[1], valid[1]});
      end
    end
    pulse_start(1);
    checks++;
    if (obs(1) !== {3'b110, 5'd0, 4'd0, exp_par(0, 1)}) begin
      errors++;
      $display("FAIL abort_restart got %h want word0", obs(1));
    end
    do_reset(1);
  endtask

  task automatic test_start_ignored;
    do_reset(0);
    ready[0] = 1'b1;
    pulse_start(0);
    for (int i = 0; i < 16; i++) begin
      start[0] = (i == 5);
      checks++;
      if (dat(0) !== 4'(i) || valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL start_ign word%0d got %h want %h", i, dat(0), i);
      end
      tick();
    end
    start[0] = 1'b0;
    tick();
    ready[0] = 1'b0;
  endtask

`ifdef PARITY_GEN_ERR_INJ_EN
  task automatic test_err_inj;
    logic want;
    do_reset(0);
    ready[0] = 1'b1;
    pulse_start(0);
    for (int i = 0; i < 16; i++) begin
      inj[0] = (i == 5);
      #1;
      want = exp_par(i, 0) ^ (i == 5);
      checks++;
      if (e[0] !== want) begin
        errors++;
        $display("FAIL err_inj word%0d got %b want %b", i, e[0], want);
      end
      inj[0] = 1'b0;
      tick();
    end
    inj[0] = 1'b1;
    tick();
    tick();
    checks++;
    if (e[0] !== 1'b0) begin
      errors++;
      $display("FAIL err_inj_idle got %b want 0", e[0]);
    end
    inj[0] = 1'b0;
    ready[0] = 1'b0;
  endtask
`endif

  // model: word on offer equals words accepted so far
  task automatic test_random(input int k);
    int          acc;
    int          hold;
    bit          active;
    bit          ev;
    bit          r;
    bit          s;
    bit          x;
    bit          fi;
    logic [12:0] want;
    do_reset(k);
    acc = 0;
    hold = 0;
    active = 0;
    for (int t = 0; t < 600; t++) begin
      r = ($urandom % 3) != 0;
      s = ($urandom % 8) == 0;
      x = ($urandom % 60) == 0;
      fi = ($urandom % 4) == 0;
`ifdef PARITY_GEN_ERR_INJ_EN
      inj[k] = fi;
`else
      fi = 1'b0;
`endif
      #1;
      ev = active && acc < 16 && hold == 0;
      want = {ev, active, active && acc == 16, 5'(acc),
              ev ? 4'(acc) : 4'd0,
              ev ? (exp_par(acc, k) ^ fi) : 1'b0};
      checks++;
      if (obs(k) !== want) begin
        errors++;
        $display("FAIL rand dut%0d t%0d got %h want %h",
                 k, t, obs(k), want);
      end
      ready[k] = r;
      start[k] = s;
      rst[k] = x;
      tick();
      if (x) begin
        active = 0;
        acc = 0;
        hold = 0;
      end else if (!active) begin
        if (s) begin
          active = 1;
          acc = 0;
          hold = 0;
        end
      end else if (acc == 16) begin
        active = 0;
      end else if (ev && r) begin
        acc++;
        hold = (acc < 16) ? gapn(k) : 0;
      end else if (hold > 0) begin
        hold--;
      end
    end
    inj[k] = 1'b0;
    do_reset(k);
  endtask

  initial begin
    test_reset();
    test_sweep_gap0();
    test_gap2();
    test_stall();
    test_abort();
    test_start_ignored();
`ifdef PARITY_GEN_ERR_INJ_EN
    test_err_inj();
`endif
    test_random(0);
    test_random(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
